// File: rtl/regfile_writeback_if.sv
// Signal bundle between the ID/EX/MEM stages, the multi-cycle units and the
// register-file write side.
interface regfile_writeback_if #(
   parameter int WORD_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic                  pipeWriteEnable;
   logic [ADDR_WIDTH-1:0] pipeWriteAddr;
   logic [WORD_WIDTH-1:0] pipeWriteResult;

   logic                  lateValid;
   logic [ADDR_WIDTH-1:0] lateDest;
   logic [WORD_WIDTH-1:0] lateResult;
   logic                  lateReady;

   logic                  issueEnable;
   logic [ADDR_WIDTH-1:0] issueDest;

   logic                  readEnableLeft;
   logic                  readEnableRight;
   logic [ADDR_WIDTH-1:0] readAddrLeft;
   logic [ADDR_WIDTH-1:0] readAddrRight;
   logic                  destCheckEnable;
   logic [ADDR_WIDTH-1:0] destCheckAddr;

   logic                  writeEnable;
   logic [ADDR_WIDTH-1:0] writeAddr;
   logic [WORD_WIDTH-1:0] writeResult;
   logic                  stall;

   modport slave (
      input  pipeWriteEnable, pipeWriteAddr, pipeWriteResult,
      input  lateValid, lateDest, lateResult,
      output lateReady,
      input  issueEnable, issueDest,
      input  readEnableLeft, readEnableRight, readAddrLeft, readAddrRight,
      input  destCheckEnable, destCheckAddr,
      output writeEnable, writeAddr, writeResult, stall
   );

   modport master (
      output pipeWriteEnable, pipeWriteAddr, pipeWriteResult,
      output lateValid, lateDest, lateResult,
      input  lateReady,
      output issueEnable, issueDest,
      output readEnableLeft, readEnableRight, readAddrLeft, readAddrRight,
      output destCheckEnable, destCheckAddr,
      input  writeEnable, writeAddr, writeResult, stall
   );
endinterface

// File: rtl/regfile_writeback.sv
// Register-file write-port owner: merges in-order pipeline writeback with
// buffered out-of-order multi-cycle results and tracks pending destinations.
module regfile_writeback #(
   parameter int FIFO_DEPTH = 4,
   parameter int WORD_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input logic                clk,
   input logic                rst,
   regfile_writeback_if.slave bus
);
   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int NUM_REGS = 1 << ADDR_WIDTH;
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

   logic [ADDR_WIDTH-1:0] r_fifoAddr [FIFO_DEPTH];
   logic [WORD_WIDTH-1:0] r_fifoData [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wrPtr;
   logic [PTR_W-1:0]      r_rdPtr;
   logic [PTR_W:0]        r_count;
   logic [NUM_REGS-1:0]   r_pending;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;
   logic [NUM_REGS-1:0]   w_setMask;
   logic [NUM_REGS-1:0]   w_clearMask;
   logic [NUM_REGS-1:0]   w_pendingNext;

   assign w_full        = (r_count == FULL_COUNT);
   assign w_empty       = (r_count == '0);
   assign bus.lateReady = rst && !w_full;

   // A late result for r0 completes the handshake but is never stored.
   assign w_push = bus.lateValid && bus.lateReady && (bus.lateDest != '0);
   assign w_pop  = rst && !bus.pipeWriteEnable && !w_empty;

   always_comb begin
      bus.writeEnable = 1'b0;
      bus.writeAddr   = '0;
      bus.writeResult = '0;
      if (rst && bus.pipeWriteEnable) begin
         bus.writeEnable = 1'b1;
         bus.writeAddr   = bus.pipeWriteAddr;
         bus.writeResult = bus.pipeWriteResult;
      end else if (w_pop) begin
         bus.writeEnable = 1'b1;
         bus.writeAddr   = r_fifoAddr[r_rdPtr];
         bus.writeResult = r_fifoData[r_rdPtr];
      end
   end

   // Applying the set mask after the clear lets a new issue win over a commit.
   always_comb begin
      w_setMask   = '0;
      w_clearMask = '0;
      if (bus.issueEnable && (bus.issueDest != '0)) begin
         w_setMask[bus.issueDest] = 1'b1;
      end
      if (w_pop) begin
         w_clearMask[r_fifoAddr[r_rdPtr]] = 1'b1;
      end
      w_pendingNext    = (r_pending & ~w_clearMask) | w_setMask;
      w_pendingNext[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wrPtr   <= '0;
         r_rdPtr   <= '0;
         r_count   <= '0;
         r_pending <= '0;
      end else begin
         r_pending <= w_pendingNext;
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + (PTR_W + 1)'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - (PTR_W + 1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifoAddr[r_wrPtr] <= bus.lateDest;
         r_fifoData[r_wrPtr] <= bus.lateResult;
      end
   end

   assign bus.stall = (bus.readEnableLeft  && r_pending[bus.readAddrLeft])  ||
                      (bus.readEnableRight && r_pending[bus.readAddrRight]) ||
                      (bus.destCheckEnable && r_pending[bus.destCheckAddr]);
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback; late results are tracked in a
// scoreboard queue and checked when they reach the write port.
module tb_regfile_writeback;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   logic [36:0] expQ [$];
   logic [36:0] sbEntry;

   regfile_writeback_if #(.WORD_WIDTH(32), .ADDR_WIDTH(5)) bus ();

   regfile_writeback #(
      .FIFO_DEPTH(4),
      .WORD_WIDTH(32),
      .ADDR_WIDTH(5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic checkBit(input string tag, input logic observed, input logic expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic pwe, input logic [4:0] pAddr, input logic [31:0] pRes,
                                input logic lv, input logic [4:0] lDest, input logic [31:0] lRes);
      @(posedge clk);
      #1;
      bus.pipeWriteEnable = pwe;
      bus.pipeWriteAddr   = pAddr;
      bus.pipeWriteResult = pRes;
      bus.lateValid       = lv;
      bus.lateDest        = lDest;
      bus.lateResult      = lRes;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // Every write not coming from the pipeline must match the oldest accepted late result.
   always @(negedge clk) begin
      if (bus.writeEnable && !bus.pipeWriteEnable) begin
         checkBit("lateWriteExpected", expQ.size() != 0, 1'b1);
         if (expQ.size() != 0) begin
            sbEntry = expQ.pop_front();
            checkOutput("lateAddr", 32'(bus.writeAddr), 32'(sbEntry[36:32]));
            checkOutput("lateData", bus.writeResult, sbEntry[31:0]);
         end
      end
   end

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      bus.pipeWriteEnable = 1'b0;
      bus.pipeWriteAddr   = '0;
      bus.pipeWriteResult = '0;
      bus.lateValid       = 1'b0;
      bus.lateDest        = '0;
      bus.lateResult      = '0;
      bus.issueEnable     = 1'b0;
      bus.issueDest       = '0;
      bus.readEnableLeft  = 1'b1;
      bus.readEnableRight = 1'b1;
      bus.readAddrLeft    = 5'd1;
      bus.readAddrRight   = 5'd2;
      bus.destCheckEnable = 1'b1;
      bus.destCheckAddr   = 5'd3;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkBit("rstLateReady", bus.lateReady, 1'b0);
      checkBit("rstWriteEnable", bus.writeEnable, 1'b0);
      checkOutput("rstWriteAddr", 32'(bus.writeAddr), 32'd0);
      checkOutput("rstWriteResult", bus.writeResult, 32'd0);
      checkBit("rstStall", bus.stall, 1'b0);
      rst = 1'b1;
      #1;
      checkBit("releaseLateReady", bus.lateReady, 1'b1);
      bus.readEnableLeft  = 1'b0;
      bus.readEnableRight = 1'b0;
      bus.destCheckEnable = 1'b0;

      // Pipeline pass-through
      applyStimulus(1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 32'd0);
      sample();
      checkBit("pipeWe", bus.writeEnable, 1'b1);
      checkOutput("pipeAddr", 32'(bus.writeAddr), 32'd5);
      checkOutput("pipeData", bus.writeResult, 32'h0000_1234);
      checkBit("pipeLateReady", bus.lateReady, 1'b1);

      // Issue r8, late result three cycles later
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      bus.issueEnable    = 1'b1;
      bus.issueDest      = 5'd8;
      bus.readEnableLeft = 1'b1;
      bus.readAddrLeft   = 5'd8;
      sample();
      checkBit("issueCycleStall", bus.stall, 1'b0);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
         bus.issueEnable = 1'b0;
         sample();
         checkBit("r8PendingStall", bus.stall, 1'b1);
      end
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hDEAD_BEEF);
      expQ.push_back({5'd8, 32'hDEAD_BEEF});
      sample();
      checkBit("r8AcceptReady", bus.lateReady, 1'b1);
      checkBit("r8NoBypass", bus.writeEnable, 1'b0);
      checkBit("r8AcceptStall", bus.stall, 1'b1);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      sample();
      checkBit("r8CommitWe", bus.writeEnable, 1'b1);
      checkOutput("r8CommitAddr", 32'(bus.writeAddr), 32'd8);
      checkBit("r8CommitStall", bus.stall, 1'b1);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      sample();
      checkBit("r8AfterStall", bus.stall, 1'b0);
      checkBit("r8AfterWe", bus.writeEnable, 1'b0);
      bus.readEnableLeft = 1'b0;

      // Pipeline busy for 6 cycles, 4 late results fill the FIFO, 5th refused
      for (int k = 0; k < 6; k++) begin
         if (k < 5) begin
            applyStimulus(1'b1, 5'(10 + k), 32'hA000_0000 + 32'(k), 1'b1,
                          (k < 4) ? 5'(16 + k) : 5'd31, 32'hB000_0000 + 32'(k));
         end else begin
            applyStimulus(1'b1, 5'(10 + k), 32'hA000_0000 + 32'(k), 1'b0, 5'd0, 32'd0);
         end
         if (k < 4) expQ.push_back({5'(16 + k), 32'hB000_0000 + 32'(k)});
         sample();
         checkOutput("busyPipeAddr", 32'(bus.writeAddr), 32'(10 + k));
         checkOutput("busyPipeData", bus.writeResult, 32'hA000_0000 + 32'(k));
         checkBit("busyLateReady", bus.lateReady, k < 4);
      end
      for (int j = 0; j < 4; j++) begin
         applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
         sample();
         checkBit("drainWe", bus.writeEnable, 1'b1);
         checkOutput("drainAddr", 32'(bus.writeAddr), 32'(16 + j));
         checkBit("drainLateReady", bus.lateReady, j != 0);
      end
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      sample();
      checkBit("drainedWe", bus.writeEnable, 1'b0);

      // Simultaneous push/pop with one entry held, pointers wrap
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'hC000_0014);
      expQ.push_back({5'd20, 32'hC000_0014});
      sample();
      checkBit("streamFirstWe", bus.writeEnable, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'(20 + i), 32'hC000_0000 + 32'(20 + i));
         expQ.push_back({5'(20 + i), 32'hC000_0000 + 32'(20 + i)});
         sample();
         checkBit("streamWe", bus.writeEnable, 1'b1);
         checkOutput("streamAddr", 32'(bus.writeAddr), 32'(19 + i));
         checkBit("streamReady", bus.lateReady, 1'b1);
      end
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      sample();
      checkOutput("streamLastAddr", 32'(bus.writeAddr), 32'd30);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      sample();
      checkBit("streamDoneWe", bus.writeEnable, 1'b0);

      // r0 late result is accepted and dropped
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
      sample();
      checkBit("r0Ready", bus.lateReady, 1'b1);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      sample();
      checkBit("r0NoWrite", bus.writeEnable, 1'b0);

      // Issue r3 in the cycle r3's head commits: pending must remain set
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h0000_0033);
      expQ.push_back({5'd3, 32'h0000_0033});
      sample();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      bus.issueEnable    = 1'b1;
      bus.issueDest      = 5'd3;
      bus.readEnableLeft = 1'b1;
      bus.readAddrLeft   = 5'd3;
      sample();
      checkOutput("r3CommitAddr", 32'(bus.writeAddr), 32'd3);
      checkBit("r3CommitStall", bus.stall, 1'b0);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      bus.issueEnable = 1'b0;
      sample();
      checkBit("r3SetWinsLeft", bus.stall, 1'b1);
      bus.readEnableLeft  = 1'b0;
      bus.readEnableRight = 1'b1;
      bus.readAddrRight   = 5'd3;
      #1;
      checkBit("r3StallRight", bus.stall, 1'b1);
      bus.readEnableRight = 1'b0;
      #1;
      checkBit("r3DisabledNoStall", bus.stall, 1'b0);
      bus.destCheckEnable = 1'b1;
      bus.destCheckAddr   = 5'd3;
      #1;
      checkBit("r3StallDest", bus.stall, 1'b1);
      bus.destCheckAddr = 5'd4;
      #1;
      checkBit("r4NoStall", bus.stall, 1'b0);
      bus.destCheckAddr = 5'd3;
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h0000_3333);
      expQ.push_back({5'd3, 32'h0000_3333});
      sample();
      checkBit("r3SecondAcceptStall", bus.stall, 1'b1);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      sample();
      checkBit("r3SecondCommitStall", bus.stall, 1'b1);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      sample();
      checkBit("r3Cleared", bus.stall, 1'b0);
      bus.destCheckEnable = 1'b0;

      // Reset mid-operation with 2 entries buffered
      applyStimulus(1'b1, 5'd1, 32'h0000_0001, 1'b1, 5'd12, 32'h0000_000C);
      bus.issueEnable = 1'b1;
      bus.issueDest   = 5'd12;
      expQ.push_back({5'd12, 32'h0000_000C});
      sample();
      applyStimulus(1'b1, 5'd2, 32'h0000_0002, 1'b1, 5'd13, 32'h0000_000D);
      bus.issueEnable    = 1'b0;
      bus.readEnableLeft = 1'b1;
      bus.readAddrLeft   = 5'd12;
      expQ.push_back({5'd13, 32'h0000_000D});
      sample();
      checkBit("preRstStall", bus.stall, 1'b1);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #1;
      checkBit("preRstWe", bus.writeEnable, 1'b1);
      #1;
      rst = 1'b0;
      expQ.delete();
      #1;
      checkBit("midRstWe", bus.writeEnable, 1'b0);
      checkBit("midRstReady", bus.lateReady, 1'b0);
      checkBit("midRstStall", bus.stall, 1'b0);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sample();
         checkBit("postRstWe", bus.writeEnable, 1'b0);
         checkBit("postRstStall", bus.stall, 1'b0);
         checkBit("postRstReady", bus.lateReady, 1'b1);
         applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      end

      checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side companion to the register file. It owns the single register-file write port and merges two result sources: the in-order pipeline writeback from EX_MEM/MEM, and out-of-order results from multi-cycle units (divider, multiplier) delivered over a valid/ready handshake and held in a 4-entry FIFO. It also keeps a 32-bit pending-destination scoreboard, so ID stalls on any register whose multi-cycle result has not yet been committed.

## Interface
Parameters:
- FIFO_DEPTH, 4: late-result buffer entries; power of two.
- WORD_WIDTH, 32: data width (`WORD_BUS`).
- ADDR_WIDTH, 5: register address width (`REG_ADDR_BUS`).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- pipeWriteEnable  in  1  pipeline writeback valid (EX_MEM regWriteEnable).
- pipeWriteAddr  in  5  pipeline destination register.
- pipeWriteResult  in  32  pipeline result (MEM result).
- lateValid  in  1  multi-cycle unit presents a result.
- lateDest  in  5  destination of the late result.
- lateResult  in  32  late result data.
- lateReady  out  1  buffer accepts the late result this cycle.
- issueEnable  in  1  ID issues a multi-cycle op this cycle.
- issueDest  in  5  destination of the issued op.
- readEnableLeft / readEnableRight  in  1  ID source-operand read enables.
- readAddrLeft / readAddrRight  in  5  ID source-operand addresses.
- destCheckEnable  in  1  ID instruction writes a register.
- destCheckAddr  in  5  that instruction's destination.
- writeEnable  out  1  to RegFile writeEnable.
- writeAddr  out  5  to RegFile writeAddr.
- writeResult  out  32  to RegFile writeResult.
- stall  out  1  scoreboard hazard to ID (OR'd with RegFile stall).

## Operation
- Write port mux, combinational:
  - When pipeWriteEnable = 1, drive the pipeline write (writeEnable = 1, pipeline address and result).
  - Otherwise, when the FIFO is non-empty, drive the FIFO head and pop it at the clock edge.
  - Otherwise writeEnable = 0, writeAddr = 0, writeResult = 0.
- The pipeline write always has priority. The FIFO head waits as many cycles as the pipeline occupies the port.
- Late handshake:
  - lateReady = rst && !full.
  - A transfer happens when lateValid && lateReady. The entry is pushed at that edge.
  - Push and pop in the same cycle are legal and leave the count unchanged.
  - lateDest = 0 is accepted and dropped: no push, no scoreboard effect.
- FIFO:
  - Read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo depth.
  - The count is log2(FIFO_DEPTH)+1 bits; full when count = FIFO_DEPTH, empty when count = 0.
- Scoreboard, pending[31:0] (bit 0 is constant 0):
  - Set on issueEnable with issueDest != 0.
  - Cleared when the FIFO head is committed (popped).
  - Set and clear of the same bit in the same cycle: set wins.
- stall = (readEnableLeft && pending[readAddrLeft]) | (readEnableRight && pending[readAddrRight]) | (destCheckEnable && pending[destCheckAddr]).
  - The destination check prevents WAW hazards. The pipeline never writes a pending register, and at most one late result per register is outstanding.

## Timing
- Reset (rst = 0, asynchronous) gives:
  - FIFO empty and pointers 0.
  - pending = 0.
  - lateReady = 0, writeEnable = 0, writeAddr = 0, writeResult = 0, stall = 0.
- The first lateReady = 1 appears combinationally after rst deasserts.
- Reset mid-operation discards buffered entries and pending bits.
- Late-result latency:
  - Accepted at edge N, the result is on the write port in cycle N+1 if the pipeline is idle, and commits to the RegFile at edge N+2 (the edge ending cycle N+1).
  - The pending bit clears at that same edge, so stall drops in cycle N+2.
- No same-cycle bypass from lateValid to the write port.
- Pipeline write: zero added latency; purely combinational pass-through.
- stall is combinational from pending and the ID inputs. pending is registered, so there is no combinational loop through issueEnable.

## Test plan
- Reset, then pipeWriteEnable=1, addr=5, result=0x1234 → same cycle writeEnable=1, writeAddr=5, writeResult=0x1234; lateReady=1.
- Issue to r8; 3 cycles later lateValid with r8 = 0xDEADBEEF and pipeline idle → stall=1 on readAddrLeft=8 until the commit edge; writeAddr=8 one cycle after acceptance; stall=0 the cycle after that.
- Pipeline writes every cycle for 6 cycles while 4 late results arrive → lateReady=0 after the 4th; nothing commits until the pipeline idles; the 4 results then commit in order, one per cycle.
- FIFO holding 1 entry with the pipeline idle, plus a simultaneous new push → count stays 1; the pointers wrap correctly over 10 back-to-back transfers.
- Issue to r3 in the same cycle the FIFO head for r3 commits → pending[3] stays 1.
- Assert rst=0 mid-cycle with 2 entries buffered → writeEnable, lateReady and stall go to 0 immediately; after release, nothing is written.
